// File: rtl/note_judge.sv
// rtl/note_judge.sv - beat-windowed strum judge with score, streak and multiplier
//
// Purpose: opens a timing window on each beat and judges one player strum
// against the expected 5-fret chord. Hit/miss are one-cycle pulses; score
// saturates at 16'hFFFF, streak at 255, and the multiplier follows the streak.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   beat, notes_to_play    beat pulse and the chord expected on that beat
//   frets, strum           raw player buttons (asynchronous, synchronized here)
//   pause, stop            freeze judging / abort song (stop wins)
//   correct_notes          frets judged correct for the current beat
//   hit, miss              judgment pulses
//   score, streak          running totals
//   multiplier             min(1 + streak/STREAK_STEP, MAX_MULT)
module note_judge #(
  parameter int WINDOW_CYCLES = 2500000,
  parameter int POINTS        = 50,
  parameter int STREAK_STEP   = 8,
  parameter int MAX_MULT      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        beat,
  input  logic [4:0]  notes_to_play,
  input  logic [4:0]  frets,
  input  logic        strum,
  input  logic        pause,
  input  logic        stop,
  output logic [4:0]  correct_notes,
  output logic        hit,
  output logic        miss,
  output logic [15:0] score,
  output logic [7:0]  streak,
  output logic [2:0]  multiplier
);

  localparam int TW = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] WINDOW = 2'd2;
  localparam logic [1:0] PAUSED = 2'd3;

  logic [4:0]    frets_meta_q, frets_sync_q;
  logic          strum_meta_q, strum_sync_q, strum_prev_q;
  logic          strum_edge;

  logic [1:0]    state_q, state_d, saved_q, saved_d;
  logic [4:0]    pending_q, pending_d;
  logic          judged_q, judged_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          hit_q, hit_d, miss_q, miss_d;
  logic [15:0]   score_q, score_d;
  logic [7:0]    streak_q, streak_d;
  logic [4:0]    correct_q, correct_d;

  logic          do_hit, do_miss, do_load;
  logic [7:0]    mult_raw;
  logic [16:0]   score_sum;

  assign strum_edge = strum_sync_q & ~strum_prev_q;

  assign mult_raw   = 8'd1 + streak_q / 8'(STREAK_STEP);
  assign multiplier = (mult_raw > 8'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];
  assign score_sum  = {1'b0, score_q} + 17'(POINTS) * 17'(multiplier);

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    pending_d = pending_q;
    judged_d  = judged_q;
    timer_d   = timer_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    score_d   = score_q;
    streak_d  = streak_q;
    correct_d = correct_q;
    do_hit    = 1'b0;
    do_miss   = 1'b0;
    do_load   = 1'b0;

    if (stop) begin
      // Abort drops the pending chord silently; score survives.
      state_d   = IDLE;
      pending_d = '0;
      judged_d  = 1'b0;
      timer_d   = '0;
      streak_d  = '0;
      correct_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (pause) begin
            saved_d = ARMED;
            state_d = PAUSED;
          end else begin
            do_miss = strum_edge;  // nothing to judge: overstrum
            do_load = beat;
          end
        end
        WINDOW: begin
          if (pause) begin
            saved_d = WINDOW;
            state_d = PAUSED;
          end else begin
            if (strum_edge) begin
              // The strum result takes the cycle's single pulse; a stale
              // resolution of the same window in this cycle is dropped.
              if (!judged_q && pending_q != 5'd0 && frets_sync_q == pending_q)
                do_hit = 1'b1;
              else
                do_miss = 1'b1;
              judged_d = 1'b1;
            end else if ((beat || timer_q == '0) && !judged_q && pending_q != 5'd0) begin
              do_miss = 1'b1;
            end
            if (beat)
              do_load = 1'b1;
            else if (timer_q == '0)
              state_d = ARMED;
            else
              timer_d = timer_q - 1'b1;
          end
        end
        PAUSED: begin
          if (!pause) state_d = saved_q;
        end
        default: state_d = IDLE;
      endcase
    end

    if (do_hit) begin
      hit_d     = 1'b1;
      score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      streak_d  = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;
      correct_d = pending_q;
    end
    if (do_miss) begin
      miss_d    = 1'b1;
      streak_d  = '0;
      correct_d = '0;
    end
    // Loading comes after judgment so a same-cycle strum scores the old chord.
    if (do_load) begin
      pending_d = notes_to_play;
      judged_d  = 1'b0;
      timer_d   = TW'(WINDOW_CYCLES - 1);
      correct_d = '0;
      state_d   = WINDOW;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frets_meta_q <= '0;
      frets_sync_q <= '0;
      strum_meta_q <= 1'b0;
      strum_sync_q <= 1'b0;
      strum_prev_q <= 1'b0;
      state_q      <= IDLE;
      saved_q      <= IDLE;
      pending_q    <= '0;
      judged_q     <= 1'b0;
      timer_q      <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      score_q      <= '0;
      streak_q     <= '0;
      correct_q    <= '0;
    end else begin
      frets_meta_q <= frets;
      frets_sync_q <= frets_meta_q;
      strum_meta_q <= strum;
      strum_sync_q <= strum_meta_q;
      strum_prev_q <= strum_sync_q;
      state_q      <= state_d;
      saved_q      <= saved_d;
      pending_q    <= pending_d;
      judged_q     <= judged_d;
      timer_q      <= timer_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      score_q      <= score_d;
      streak_q     <= streak_d;
      correct_q    <= correct_d;
    end
  end

  assign correct_notes = correct_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign score         = score_q;
  assign streak        = streak_q;

endmodule
